multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 16: maximum cycles spent waiting for mem_ready before a wait state aborts.
REQ-002 The block SHALL have parameter CNT_W, default 5: width of the wait counter, which must hold MEM_TIMEOUT.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all state changes on rising edge
  reset_n  in  1  asynchronous, active-low reset
  opcode  in  6  instruction[31:26] from IR; stable from DECODE onward
  mem_ready  in  1  memory completes the current read/write this cycle
  pc_write  out  1  unconditional PC load
  pc_write_cond  out  1  PC load if ALU zero
  iord  out  1  memory address: 0=PC, 1=ALUOut
  mem_read  out  1  memory read request
  mem_write  out  1  memory write request
  ir_write  out  1  IR load
  mem_to_reg  out  1  write-back source: 1=MDR, 0=ALUOut
  reg_dst  out  1  destination register: 1=rd, 0=rt
  reg_write  out  1  register file write enable
  alu_src_a  out  1  ALU A input: 0=PC, 1=rs
  alu_src_b  out  2  ALU B input: 00=rt, 01=const 4, 10=sign/zero-extended immediate, 11=shifted immediate
  alu_op  out  2  ALU op: 00=add, 01=sub, 10=funct, 11=opcode-decoded immediate op
  pc_source  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
  state  out  4  current state encoding, for debug
  illegal  out  1  sticky: an unsupported opcode was decoded
  bus_err  out  1  sticky: a memory wait timed out

Function
REQ-004 The state machine SHALL use this encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, IEXEC=10, IWB=11, JUMP=12.
REQ-005 The state SHALL be a register; every control output SHALL be 0 except as listed per state below.
REQ-006 IDLE: all controls 0; next state FETCH unconditionally.
REQ-007 FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00. In the cycle mem_ready=1, pc_write=1 and ir_write=1 (Mealy terms) and the next state is DECODE; otherwise stay in FETCH.
REQ-008 DECODE: alu_src_b=11, alu_op=00. Next state by opcode:
  000000 -> EXEC
  100011 or 101011 -> MEMADR
  000100 -> BRANCH
  001101 or 001111 -> IEXEC
  000010 -> JUMP
  any other opcode -> FETCH, and illegal is set.
REQ-009 MEMADR: alu_src_a=1, alu_src_b=10; next state MEMRD if opcode=100011, else MEMWR.
REQ-010 MEMRD: iord=1, mem_read=1; on mem_ready -> MEMWB, else hold.
REQ-011 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next state FETCH.
REQ-012 MEMWR: iord=1, mem_write=1; on mem_ready -> FETCH, else hold.
REQ-013 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next state ALUWB. ALUWB: reg_dst=1, reg_write=1; next state FETCH.
REQ-014 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; next state FETCH.
REQ-015 IEXEC: alu_src_a=1, alu_src_b=10, alu_op=11; next state IWB. IWB: reg_write=1, reg_dst=0; next state FETCH.
REQ-016 JUMP: pc_write=1, pc_source=10; next state FETCH.
REQ-017 Wait counter: cleared on entry to FETCH, MEMRD or MEMWR; increments each cycle in those states while mem_ready=0; saturates at MEM_TIMEOUT.
REQ-018 Timeout: if the counter equals MEM_TIMEOUT-1 and mem_ready=0, the next state SHALL be FETCH, bus_err SHALL be set, and no pc_write, ir_write or reg_write SHALL occur.
REQ-019 mem_ready asserted in the same cycle as timeout SHALL win: normal completion, no bus_err.
REQ-020 illegal and bus_err SHALL be cleared only by reset.
REQ-021 Instruction latency with mem_ready tied high: R-type 4 cycles, lw 5, sw 4, beq 3, ori/lui 4, j 3.

Reset
REQ-022 reset_n=0 SHALL asynchronously force state=IDLE, clear the wait counter, illegal and bus_err, and drive every output to 0.
REQ-023 Reset asserted mid-instruction SHALL abandon the instruction with no further write strobes.
REQ-024 After reset deassertion, FETCH SHALL be entered on the first clock edge.

Verification
REQ-025 Reset release, mem_ready=1, opcode=000000 -> states 0,1,2,7,8,1; reg_write=1 with reg_dst=1 in state 8 only.
REQ-026 opcode=100011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles; then MEMWB with mem_to_reg=1; bus_err=0.
REQ-027 opcode=000100 -> BRANCH for one cycle with pc_write_cond=1, alu_op=01, pc_source=01.
REQ-028 opcode=111111 -> DECODE goes to FETCH, illegal=1, and illegal stays 1 until reset.
REQ-029 mem_ready held 0 in FETCH, MEM_TIMEOUT=16 -> FETCH re-entered after 16 cycles, bus_err=1, ir_write never asserted.
REQ-030 reset_n pulsed low during MEMWR -> mem_write drops to 0 immediately (asynchronous), state=0.

Source files
------------

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Controller-to-datapath bundle for the multicycle controller:
//                instruction opcode and memory handshake in, control strobes,
//                debug state and sticky error flags out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state;
  logic       illegal;
  logic       bus_err;

  // Controller side
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, illegal, bus_err
  );

  // Datapath / memory side
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, illegal, bus_err
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multicycle MIPS-style control FSM with memory wait states,
//                wait timeout (bus_err) and unsupported-opcode flag (illegal).
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11,
    JUMP   = 4'd12
  } state_t;

  localparam logic [5:0]       c_op_rtype   = 6'b000000;
  localparam logic [5:0]       c_op_lw      = 6'b100011;
  localparam logic [5:0]       c_op_sw      = 6'b101011;
  localparam logic [5:0]       c_op_beq     = 6'b000100;
  localparam logic [5:0]       c_op_ori     = 6'b001101;
  localparam logic [5:0]       c_op_lui     = 6'b001111;
  localparam logic [5:0]       c_op_j       = 6'b000010;
  localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] c_timeout_m1 = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic             wait_st;
  logic             timeout;

  // A wait state gives up when the last allowed cycle passes without mem_ready;
  // a same-cycle mem_ready takes priority over the abort.
  assign wait_st = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign timeout = wait_st && !bus.mem_ready && (cnt_q == c_timeout_m1);

  assign bus.state   = state_q;
  assign bus.illegal = illegal_q;
  assign bus.bus_err = bus_err_q;

  // State, wait counter and sticky error flags; reset abandons everything at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Counter only advances while holding in a wait state; any other move clears it
  always_comb begin
    cnt_d = '0;
    if (wait_st && !bus.mem_ready && !timeout) begin
      cnt_d = (cnt_q == c_timeout) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Next-state and control decode (Moore per state, Mealy completion strobes in FETCH)
  always_comb begin
    state_d           = state_q;
    illegal_d         = illegal_q;
    bus_err_d         = bus_err_q;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          bus.pc_write = 1'b1;
          bus.ir_write = 1'b1;
          state_d      = DECODE;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = FETCH;
        end
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          c_op_rtype:       state_d = EXEC;
          c_op_lw, c_op_sw: state_d = MEMADR;
          c_op_beq:         state_d = BRANCH;
          c_op_ori, c_op_lui: state_d = IEXEC;
          c_op_j:           state_d = JUMP;
          default: begin
            illegal_d = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = (bus.opcode == c_op_lw) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.iord     = 1'b1;
        bus.mem_read = 1'b1;
        if (bus.mem_ready) begin
          state_d = MEMWB;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = FETCH;
        end
      end
      MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_d        = FETCH;
      end
      MEMWR: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
        if (bus.mem_ready) begin
          state_d = FETCH;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = FETCH;
        end
      end
      EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_d       = ALUWB;
      end
      ALUWB: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
        state_d       = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        state_d           = FETCH;
      end
      IEXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = 2'b11;
        state_d       = IWB;
      end
      IWB: begin
        bus.reg_write = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        state_d       = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire
